div_ctrl: RTL and testbench

- Control unit for the team's sequential restoring divider.
- Drives the load and shift strobes of the remainder register R (N+1 bits), the dividend/quotient register X (N bits) and the divisor register Y (N bits). Also selects the R load source and counts iterations.
- Takes status from the datapath (X msb, R>=Y compare, Y==0) and returns a go/done handshake to the host.
- Quotient ends in X and remainder ends in R.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_cnt.sv | 40 ++++
 rtl/div_ctrl.sv | 156 +++++++++++++++
 tb/tb_div_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring-divider controller.
package div_pkg;

   localparam int DIV_N_DEFAULT = 4;

   localparam logic R_SEL_ZERO = 1'b0;
   localparam logic R_SEL_DIFF = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_SHIFT = 3'd3,
      S_TEST  = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

endpackage

// File: rtl/div_cnt.sv
// Iteration down-counter for the divider: load, decrement, zero/one flags.
// Decrement saturates at zero so the count can never wrap.
module div_cnt #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld,
   input  logic [CW-1:0] ld_val,
   input  logic          dec,
   output logic          zero,
   output logic          one
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // next count: load has priority over decrement
   always_comb begin
      cnt_d = cnt_q;
      if (ld) begin
         cnt_d = ld_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);
   assign one  = (cnt_q == CW'(1));

endmodule

// File: rtl/div_ctrl.sv
// Control FSM for the sequential restoring divider (R: N+1 bits, X/Y: N bits).
// Quotient ends in X, remainder in R.
// Optional build macro DIV_ERR_STICKY_EN: err stays high after a divide-by-zero
// until the next accepted go or reset.
//
// state | meaning
// IDLE  | waiting for go
// LOAD  | clear R, load X and Y, preset iteration count
// CHECK | divisor zero test
// SHIFT | shift X msb into R
// TEST  | quotient bit = R>=Y; subtract when set; shift bit into X
// DONE  | one-cycle completion pulse
// ERR   | divide-by-zero: done+err, no iterations run
module div_ctrl
   import div_pkg::*;
#(
   parameter int N  = DIV_N_DEFAULT,
   parameter int CW = $clog2(N + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic go,
   input  logic x_msb,
   input  logic r_ge_y,
   input  logic y_zero,
   output logic r_ld,
   output logic r_sel,
   output logic r_sl,
   output logic r_shb,
   output logic x_ld,
   output logic x_sl,
   output logic x_shb,
   output logic y_ld,
   output logic busy,
   output logic done,
   output logic err
);

   state_t state_q;
   state_t state_d;
   logic   cnt_ld;
   logic   cnt_dec;
   logic   cnt_zero;
   logic   cnt_one;

   div_cnt #(.CW(CW)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .ld     (cnt_ld),
      .ld_val (CW'(N)),
      .dec    (cnt_dec),
      .zero   (cnt_zero),
      .one    (cnt_one)
   );

   // next-state and strobe decode from the current state and datapath status
   always_comb begin
      state_d = state_q;
      r_ld    = 1'b0;
      r_sel   = R_SEL_ZERO;
      r_sl    = 1'b0;
      r_shb   = 1'b0;
      x_ld    = 1'b0;
      x_sl    = 1'b0;
      x_shb   = 1'b0;
      y_ld    = 1'b0;
      done    = 1'b0;
      cnt_ld  = 1'b0;
      cnt_dec = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go) state_d = S_LOAD;
         end
         S_LOAD: begin
            r_ld    = 1'b1;
            r_sel   = R_SEL_ZERO;
            x_ld    = 1'b1;
            y_ld    = 1'b1;
            cnt_ld  = 1'b1;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            state_d = y_zero ? S_ERR : S_SHIFT;
         end
         S_SHIFT: begin
            r_sl    = 1'b1;
            r_shb   = x_msb;
            state_d = S_TEST;
         end
         S_TEST: begin
            x_sl    = 1'b1;
            x_shb   = r_ge_y;
            if (r_ge_y) begin
               r_ld  = 1'b1;
               r_sel = R_SEL_DIFF;
            end
            cnt_dec = 1'b1;
            // zero is only reachable if the count was corrupted; exit rather than spin
            state_d = (cnt_one || cnt_zero) ? S_DONE : S_SHIFT;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy = (state_q != S_IDLE);

`ifdef DIV_ERR_STICKY_EN
   logic err_q;
   logic err_d;

   // sticky error: set on leaving ERR, cleared when a new go is accepted
   always_comb begin
      err_d = err_q;
      if (state_q == S_ERR) begin
         err_d = 1'b1;
      end else if ((state_q == S_IDLE) && go) begin
         err_d = 1'b0;
      end
   end

   // state and sticky error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q || (state_q == S_ERR);
`else
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign err = (state_q == S_ERR);
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural R/X/Y datapath plus directed division vectors.
module tb_div_ctrl;
   import div_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic go = 1'b0;
   logic x_msb, r_ge_y, y_zero;
   logic r_ld, r_sel, r_sl, r_shb, x_ld, x_sl, x_shb, y_ld, busy, done, err;

   logic [N-1:0] dvd = '0;
   logic [N-1:0] dvs = '0;
   logic [N:0]   r_m = '0;
   logic [N-1:0] x_m = '0;
   logic [N-1:0] y_m = '0;

   int n_chk = 0;
   int n_err = 0;

`ifdef DIV_ERR_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   always #5 clk = ~clk;

   div_ctrl #(.N(N)) dut (
      .clk(clk), .rst(rst), .go(go),
      .x_msb(x_msb), .r_ge_y(r_ge_y), .y_zero(y_zero),
      .r_ld(r_ld), .r_sel(r_sel), .r_sl(r_sl), .r_shb(r_shb),
      .x_ld(x_ld), .x_sl(x_sl), .x_shb(x_shb), .y_ld(y_ld),
      .busy(busy), .done(done), .err(err)
   );

   // datapath model
   assign x_msb  = x_m[N-1];
   assign r_ge_y = (r_m >= {1'b0, y_m});
   assign y_zero = (y_m == '0);

   always @(posedge clk) begin
      if (r_ld) r_m <= r_sel ? (r_m - {1'b0, y_m}) : '0;
      else if (r_sl) r_m <= {r_m[N-1:0], r_shb};
      if (x_ld) x_m <= dvd;
      else if (x_sl) x_m <= {x_m[N-2:0], x_shb};
      if (y_ld) y_m <= dvs;
   end

   // strobe exclusivity monitor
   always @(negedge clk) begin
      if (!rst && r_ld && r_sl) begin
         n_err++;
         $display("FAIL r_ld_r_sl_overlap: both high at %0t, required never together", $time);
      end
      if (!rst && x_ld && x_sl) begin
         n_err++;
         $display("FAIL x_ld_x_sl_overlap: both high at %0t, required never together", $time);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      int           rp1;
      int           rp2;
      int           e_cyc;
      logic [N-1:0] e_q;
      logic [N:0]   e_r;
      logic         e_err;
   } vec_t;

   // one division; caller is at a negedge, returns at a negedge
   task automatic apply(input vec_t v);
      int   dcyc, ndone, nsl;
      logic busy_ok, err_done, err_c1, err_after;
      logic [N-1:0] q;
      logic [N:0]   rr;
      dcyc = -1; ndone = 0; nsl = 0; busy_ok = 1'b1;
      err_done = 1'b0; err_c1 = 1'b1; err_after = 1'b0; q = '0; rr = '0;
      dvd = v.a; dvs = v.b; go = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         go = (k == v.rp1) || (k == v.rp2);
         if (k == 1) err_c1 = err;
         if (r_sl) nsl++;
         if (done) begin
            ndone++;
            if (dcyc < 0) begin
               dcyc = k; err_done = err; q = x_m; rr = r_m;
            end
         end
         if (dcyc < 0 && !busy) busy_ok = 1'b0;
         if (dcyc > 0 && k > dcyc && busy) busy_ok = 1'b0;
         if (dcyc > 0 && k == dcyc + 2) err_after = err;
         if (dcyc > 0 && k >= dcyc + 3) break;
      end
      go = 1'b0;
      chk($sformatf("done_cycle %0d/%0d", v.a, v.b), dcyc, v.e_cyc);
      chk($sformatf("done_pulses %0d/%0d", v.a, v.b), ndone, 1);
      chk($sformatf("quotient %0d/%0d", v.a, v.b), int'(q), int'(v.e_q));
      chk($sformatf("remainder %0d/%0d", v.a, v.b), int'(rr), int'(v.e_r));
      chk($sformatf("err_at_done %0d/%0d", v.a, v.b), int'(err_done), int'(v.e_err));
      chk($sformatf("shift_count %0d/%0d", v.a, v.b), nsl, v.e_err ? 0 : N);
      chk($sformatf("busy_window %0d/%0d", v.a, v.b), int'(busy_ok), 1);
      chk($sformatf("err_in_load %0d/%0d", v.a, v.b), int'(err_c1), 0);
      chk($sformatf("err_after %0d/%0d", v.a, v.b), int'(err_after), int'(STICKY && v.e_err));
   endtask

   function automatic int outs();
      return int'({r_ld, r_sel, r_sl, r_shb, x_ld, x_sl, x_shb, y_ld, busy, done, err});
   endfunction

   vec_t tbl[10];

   initial begin
      int   k1, k2, b12, b13;
      logic [N-1:0] q2;
      logic [N:0]   r2;

      tbl[0] = '{4'd13, 4'd3,  0, 0, 11, 4'd4,  5'd1, 1'b0};
      tbl[1] = '{4'd15, 4'd1,  0, 0, 11, 4'd15, 5'd0, 1'b0};
      tbl[2] = '{4'd5,  4'd7,  0, 0, 11, 4'd0,  5'd5, 1'b0};
      tbl[3] = '{4'd9,  4'd0,  0, 0, 3,  4'd9,  5'd0, 1'b1};
      tbl[4] = '{4'd8,  4'd2,  0, 0, 11, 4'd4,  5'd0, 1'b0};
      tbl[5] = '{4'd0,  4'd3,  0, 0, 11, 4'd0,  5'd0, 1'b0};
      tbl[6] = '{4'd15, 4'd15, 0, 0, 11, 4'd1,  5'd0, 1'b0};
      tbl[7] = '{4'd14, 4'd4,  0, 0, 11, 4'd3,  5'd2, 1'b0};
      tbl[8] = '{4'd12, 4'd5,  4, 9, 11, 4'd2,  5'd2, 1'b0};
      tbl[9] = '{4'd6,  4'd4,  0, 0, 11, 4'd1,  5'd2, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset_outputs", outs(), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outputs", outs(), 0);

      for (int i = 0; i < 9; i++) apply(tbl[i]);

      // asynchronous reset in the middle of 13/3
      dvd = 4'd13; dvs = 4'd3; go = 1'b1;
      @(posedge clk);
      @(negedge clk);
      go = 1'b0;
      repeat (5) @(negedge clk);
      chk("busy_before_rst", int'(busy), 1);
      #1 rst = 1'b1;
      #1;
      chk("outputs_async_rst", outs(), 0);
      chk("state_async_rst", int'(dut.state_q), int'(S_IDLE));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      apply(tbl[9]);

      // go held high through DONE: one IDLE cycle, then a second division
      k1 = -1; k2 = -1; b12 = -1; b13 = -1; q2 = '0; r2 = '0;
      dvd = 4'd13; dvs = 4'd3; go = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 12) b12 = int'(busy);
         if (k == 13) b13 = int'(busy);
         if (done && k1 < 0) k1 = k;
         else if (done && k2 < 0) begin
            k2 = k; q2 = x_m; r2 = r_m; go = 1'b0;
         end
         if (k2 > 0 && k >= k2 + 2) break;
      end
      go = 1'b0;
      chk("held_go_done1", k1, 11);
      chk("held_go_idle_gap", b12, 0);
      chk("held_go_restart", b13, 1);
      chk("held_go_done2", k2, 23);
      chk("held_go_quotient", int'(q2), 4);
      chk("held_go_remainder", int'(r2), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
